gradient_nms_array: RTL and testbench
=====================================

GRADIENT_NMS_ARRAY -- requirements
Module: gradient_nms_array

Interface
REQ-001 The block SHALL expose parameter DW, default 14, unsigned input pixel width.
REQ-002 The block SHALL expose parameter BW, default 2, block width in pixels (1..4).
REQ-003 The block SHALL expose parameter BH, default 2, block height in pixels (1..4); NPIX = BW*BH.
REQ-004 The block SHALL expose parameter THR, default 0, magnitude threshold for mode 2; width GW.
REQ-005 Ports SHALL be: clk  in  1  clock; rst  in  1  asynchronous active-high reset; one clock domain, all logic on rising clk.
REQ-006 in_valid  in  1  tap strobe.
REQ-007 i_data  in  DW  tap pixel value.
REQ-008 i_count  in  4  tap index 0..8, raster order in the 3x3 window.
REQ-009 mode  in  2  0=NMS, 1=magnitude only, 2=NMS plus threshold, 3=treated as 0.
REQ-010 o_data  out  GW=DW+3  output magnitude.
REQ-011 o_angle  out  2  quantised direction: 0=0deg, 1=45deg, 2=90deg, 3=135deg.
REQ-012 o_idx  out  4  raster index of the output pixel within the block.
REQ-013 o_valid  out  1  output strobe; finish_flag  out  1  block-done pulse; busy  out  1  taps are not accepted.

Function
REQ-014 Kernels SHALL be Gx=[-1 0 1;-2 0 2;-1 0 1] and Gy=[-1 -2 -1;0 0 0;1 2 1], indexed by i_count in raster order.
REQ-015 Accumulators SHALL be signed DW+4 bits; a tap with i_count==0 SHALL load rather than add; G=|Gx|+|Gy| SHALL be exact in GW bits.
REQ-016 Angle SHALL use 7-bit fraction constants 53 (tan22.5) and 309 (tan67.5): |Gy|*128 < |Gx|*53 gives 0; else |Gy|*128 > |Gx|*309 gives 90; else sign(Gx) XOR sign(Gy) gives 135 if 1, 45 if 0.
REQ-017 Gx=Gy=0 SHALL therefore give angle 45.
REQ-018 FSM states SHALL be ACC, GRAD, ANG, EMIT; reset state is ACC.
REQ-019 ACC: taps accepted while in_valid=1 and busy=0; i_count>8 is ignored; an accepted tap with i_count==8 moves to GRAD.
REQ-020 GRAD: G and signs are registered. ANG: angle is computed and {G,angle} stored at slot pcnt; pcnt increments.
REQ-021 ANG SHALL go to EMIT when pcnt reaches NPIX-1, else back to ACC.
REQ-022 busy SHALL be 1 in GRAD, ANG and EMIT; taps presented while busy SHALL be dropped with no effect.
REQ-023 mode SHALL be latched on the accepted i_count==0 tap of slot 0 and held for the whole block.
REQ-024 NMS neighbours of (r,c): angle 0 -> (r,c+/-1); 90 -> (r+/-1,c); 45 -> (r-1,c-1),(r+1,c+1); 135 -> (r-1,c+1),(r+1,c-1).
REQ-025 Neighbours outside the block SHALL be ignored.
REQ-026 A pixel SHALL be zeroed if its G is strictly less than any in-block neighbour; ties keep the pixel.
REQ-027 Mode 1 SHALL output the raw G; mode 2 SHALL additionally zero any result below THR.
REQ-028 EMIT SHALL output slots 0..NPIX-1 on consecutive cycles, one per cycle, with o_valid=1, o_idx=slot and o_angle=stored angle.
REQ-029 finish_flag SHALL be 1 only in the cycle carrying the last output; EMIT then returns to ACC and clears pcnt.
REQ-030 Latency: if tap 8 of the last pixel is sampled at edge T, the first o_valid SHALL appear after edge T+3.
REQ-031 o_data, o_angle and o_idx SHALL be 0 whenever o_valid=0.
REQ-032 With NPIX=1 the block SHALL emit after every window, with no suppression in any mode.

Reset
REQ-033 rst=1 SHALL immediately force: state ACC; pcnt, accumulators and stored slots 0; all outputs 0.
REQ-034 A reset mid-block or mid-EMIT SHALL discard the partial block, with no finish_flag.

Verification
REQ-035 Left column 0, middle 0, right column 100 (DW=14, BW=BH=1) -> o_data=400, o_angle=0, finish_flag=1 with o_valid.
REQ-036 Top row 0, bottom row 100 -> o_data=400, o_angle=2; flat window of 50s -> o_data=0, o_angle=1.
REQ-037 2x2 block, mode 0: slot0 edge 400/angle 0, slot1 right column 75 (G=300, angle 0), slots 2-3 flat -> outputs 400,0,0,0 on 4 consecutive cycles, finish on the 4th.
REQ-038 Same stimulus in mode 1 -> 400,300,0,0; in mode 2 with THR=350 -> 400,0,0,0.
REQ-039 Right column 16383, left 0 -> o_data=65532 with no overflow; taps sent during EMIT -> ignored, busy=1.
REQ-040 rst pulse after slot 1 is stored, then a full block -> only the new block is output, with correct values.

Source files
------------

// File: rtl/gradient_nms_array.sv
// Sobel gradient over a BWxBH block of 3x3 windows. Magnitude and quantised direction are
// stored per pixel, then in-block non-maximum suppression emits the block in raster order.
module gradient_nms_array #(
    parameter int            DW  = 14,
    parameter int            BW  = 2,
    parameter int            BH  = 2,
    parameter logic [DW+2:0] THR = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] i_data,
    input  logic [3:0]    i_count,
    input  logic [1:0]    mode,
    output logic [DW+2:0] o_data,
    output logic [1:0]    o_angle,
    output logic [3:0]    o_idx,
    output logic          o_valid,
    output logic          finish_flag,
    output logic          busy
);
    localparam int GW   = DW + 3;
    localparam int AW   = DW + 4;
    localparam int NPIX = BW * BH;
    // Wide enough to hold |G| * 309 without wrapping.
    localparam int MW   = AW + 9;

    typedef enum logic [1:0] {ST_ACC, ST_GRAD, ST_ANG, ST_EMIT} state_t;

    state_t               state_q, state_d;
    logic signed [AW-1:0] gx_q, gx_d, gy_q, gy_d;
    logic [AW-1:0]        ax_q, ax_d, ay_q, ay_d;
    logic                 sx_q, sx_d, sy_q, sy_d;
    logic [GW-1:0]        mag_q, mag_d;
    logic [3:0]           pcnt_q, pcnt_d;
    logic [3:0]           eidx_q, eidx_d;
    logic [1:0]           mode_q, mode_d;
    logic [GW-1:0]        slot_g_q [NPIX];
    logic [GW-1:0]        slot_g_d [NPIX];
    logic [1:0]           slot_a_q [NPIX];
    logic [1:0]           slot_a_d [NPIX];
    logic [GW-1:0]        o_data_q, o_data_d;
    logic [1:0]           o_angle_q, o_angle_d;
    logic [3:0]           o_idx_q, o_idx_d;
    logic                 o_valid_q, o_valid_d;
    logic                 finish_q, finish_d;

    // Kernel-weighted contribution of the current tap.
    logic                 tap_ok;
    logic signed [AW-1:0] pix, tx, ty;

    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        pix    = signed'({4'b0000, i_data});
        tx     = '0;
        ty     = '0;
        tap_ok = (state_q == ST_ACC) && in_valid && (i_count <= 4'd8);
        case (i_count)
            4'd0: begin tx = -pix;        ty = -pix;        end
            4'd1: begin                   ty = -(pix <<< 1); end
            4'd2: begin tx = pix;         ty = -pix;        end
            4'd3: begin tx = -(pix <<< 1);                  end
            4'd5: begin tx = pix <<< 1;                     end
            4'd6: begin tx = -pix;        ty = pix;         end
            4'd7: begin                   ty = pix <<< 1;   end
            4'd8: begin tx = pix;         ty = pix;         end
            default: ;
        endcase
    end

    // Direction quantisation with 7-bit fixed-point tan(22.5) and tan(67.5).
    logic [MW-1:0] ay_x128, ax_x53, ax_x309;
    logic [1:0]    ang;

    always_comb begin
        ay_x128 = MW'(ay_q) << 7;
        ax_x53  = MW'(ax_q) * MW'(53);
        ax_x309 = MW'(ax_q) * MW'(309);
        if (ay_x128 < ax_x53) begin
            ang = 2'd0;
        end else if (ay_x128 > ax_x309) begin
            ang = 2'd2;
        end else begin
            ang = (sx_q ^ sy_q) ? 2'd3 : 2'd1;
        end
    end

    // Suppression of the slot being emitted against its two in-block neighbours.
    logic [GW-1:0] cur_g, nms_g;
    logic [1:0]    cur_a, eff_mode;
    logic          suppress;

    always_comb begin
        int r, c, dr, dc;
        cur_g    = '0;
        cur_a    = '0;
        suppress = 1'b0;
        for (int s = 0; s < NPIX; s++) begin
            if (eidx_q == 4'(s)) begin
                cur_g = slot_g_q[s];
                cur_a = slot_a_q[s];
            end
        end
        r = int'(eidx_q) / BW;
        c = int'(eidx_q) % BW;
        case (cur_a)
            2'd0:    begin dr = 0; dc = 1;  end
            2'd1:    begin dr = 1; dc = 1;  end
            2'd2:    begin dr = 1; dc = 0;  end
            default: begin dr = 1; dc = -1; end
        endcase
        // Rows and columns are matched separately, so off-block neighbours never alias.
        for (int s = 0; s < NPIX; s++) begin
            if (((s / BW == r + dr) && (s % BW == c + dc)) ||
                ((s / BW == r - dr) && (s % BW == c - dc))) begin
                if (slot_g_q[s] > cur_g) suppress = 1'b1;
            end
        end
        eff_mode = (mode_q == 2'd3) ? 2'd0 : mode_q;
        nms_g    = cur_g;
        if ((eff_mode != 2'd1) && suppress) nms_g = '0;
        if ((eff_mode == 2'd2) && (nms_g < THR)) nms_g = '0;
    end

    always_comb begin
        state_d   = state_q;
        gx_d      = gx_q;
        gy_d      = gy_q;
        ax_d      = ax_q;
        ay_d      = ay_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        mag_d     = mag_q;
        pcnt_d    = pcnt_q;
        eidx_d    = eidx_q;
        mode_d    = mode_q;
        slot_g_d  = slot_g_q;
        slot_a_d  = slot_a_q;
        o_data_d  = '0;
        o_angle_d = '0;
        o_idx_d   = '0;
        o_valid_d = 1'b0;
        finish_d  = 1'b0;

        case (state_q)
            ST_ACC: begin
                if (tap_ok) begin
                    gx_d = (i_count == 4'd0) ? tx : gx_q + tx;
                    gy_d = (i_count == 4'd0) ? ty : gy_q + ty;
                    if ((i_count == 4'd0) && (pcnt_q == 4'd0)) mode_d = mode;
                    if (i_count == 4'd8) state_d = ST_GRAD;
                end
            end
            ST_GRAD: begin
                ax_d    = gx_q[AW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
                ay_d    = gy_q[AW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
                sx_d    = gx_q[AW-1];
                sy_d    = gy_q[AW-1];
                mag_d   = GW'(ax_d + ay_d);
                state_d = ST_ANG;
            end
            ST_ANG: begin
                for (int s = 0; s < NPIX; s++) begin
                    if (pcnt_q == 4'(s)) begin
                        slot_g_d[s] = mag_q;
                        slot_a_d[s] = ang;
                    end
                end
                pcnt_d  = pcnt_q + 4'd1;
                state_d = (pcnt_q == 4'(NPIX - 1)) ? ST_EMIT : ST_ACC;
            end
            ST_EMIT: begin
                o_valid_d = 1'b1;
                o_data_d  = nms_g;
                o_angle_d = cur_a;
                o_idx_d   = eidx_q;
                if (eidx_q == 4'(NPIX - 1)) begin
                    finish_d = 1'b1;
                    eidx_d   = '0;
                    pcnt_d   = '0;
                    state_d  = ST_ACC;
                end else begin
                    eidx_d = eidx_q + 4'd1;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ACC;
            gx_q      <= '0;
            gy_q      <= '0;
            ax_q      <= '0;
            ay_q      <= '0;
            sx_q      <= 1'b0;
            sy_q      <= 1'b0;
            mag_q     <= '0;
            pcnt_q    <= '0;
            eidx_q    <= '0;
            mode_q    <= '0;
            // NOTE: the slot store is small and must read as 0 after reset, so it is reset.
            for (int s = 0; s < NPIX; s++) begin
                slot_g_q[s] <= '0;
                slot_a_q[s] <= '0;
            end
            o_data_q  <= '0;
            o_angle_q <= '0;
            o_idx_q   <= '0;
            o_valid_q <= 1'b0;
            finish_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            ax_q      <= ax_d;
            ay_q      <= ay_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            mag_q     <= mag_d;
            pcnt_q    <= pcnt_d;
            eidx_q    <= eidx_d;
            mode_q    <= mode_d;
            slot_g_q  <= slot_g_d;
            slot_a_q  <= slot_a_d;
            o_data_q  <= o_data_d;
            o_angle_q <= o_angle_d;
            o_idx_q   <= o_idx_d;
            o_valid_q <= o_valid_d;
            finish_q  <= finish_d;
        end
    end

    assign o_data      = o_data_q;
    assign o_angle     = o_angle_q;
    assign o_idx       = o_idx_q;
    assign o_valid     = o_valid_q;
    assign finish_flag = finish_q;
    assign busy        = (state_q != ST_ACC);

endmodule

// File: tb/tb_gradient_nms_array.sv
// Directed bench: a 1x1 instance for gradient/angle vectors and two 2x2 instances
// (THR 0 and THR 350) for suppression, mode, busy-drop and reset sequences.
module tb_gradient_nms_array;
    localparam int DW = 14;
    localparam int GW = DW + 3;

    typedef logic [8:0][DW-1:0] win_t;

    typedef struct {
        win_t       pix;
        logic [1:0] md;
        bit         junk;
        int         exp_g;
        int         exp_a;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    vld;
    logic [DW-1:0] i_data;
    logic [3:0]    i_count;
    logic [1:0]    mode;
    logic [GW-1:0] od [3];
    logic [1:0]    oa [3];
    logic [3:0]    oi [3];
    logic          ov [3];
    logic          ff [3];
    logic          bz [3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gradient_nms_array #(.DW(DW), .BW(1), .BH(1)) u_1x1 (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .i_data(i_data), .i_count(i_count),
        .mode(mode), .o_data(od[0]), .o_angle(oa[0]), .o_idx(oi[0]), .o_valid(ov[0]),
        .finish_flag(ff[0]), .busy(bz[0]));

    gradient_nms_array #(.DW(DW), .BW(2), .BH(2)) u_2x2 (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .i_data(i_data), .i_count(i_count),
        .mode(mode), .o_data(od[1]), .o_angle(oa[1]), .o_idx(oi[1]), .o_valid(ov[1]),
        .finish_flag(ff[1]), .busy(bz[1]));

    gradient_nms_array #(.DW(DW), .BW(2), .BH(2), .THR(17'd350)) u_2x2_thr (
        .clk(clk), .rst(rst), .in_valid(vld[2]), .i_data(i_data), .i_count(i_count),
        .mode(mode), .o_data(od[2]), .o_angle(oa[2]), .o_idx(oi[2]), .o_valid(ov[2]),
        .finish_flag(ff[2]), .busy(bz[2]));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic win_t w9(input int a, input int b, input int c, input int d,
                                input int e, input int f, input int g, input int h,
                                input int i);
        win_t p;
        p[0] = DW'(a); p[1] = DW'(b); p[2] = DW'(c);
        p[3] = DW'(d); p[4] = DW'(e); p[5] = DW'(f);
        p[6] = DW'(g); p[7] = DW'(h); p[8] = DW'(i);
        return p;
    endfunction

    function automatic win_t edge_r(input int v);
        return w9(0, 0, v, 0, 0, v, 0, 0, v);
    endfunction

    function automatic win_t flat(input int v);
        return w9(v, v, v, v, v, v, v, v, v);
    endfunction

    task automatic wait_idle(input int s);
        int n = 0;
        while (bz[s] === 1'b1 && n < 50) begin
            vld[s] = 1'b0;
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_chk++;
            n_err++;
            $display("FAIL busy timeout: dut %0d still busy after %0d cycles", s, n);
        end
    endtask

    // Presents taps 0..8 on consecutive idle cycles; optional out-of-range tap mid-window.
    task automatic send_win(input int s, input win_t p, input bit junk);
        for (int k = 0; k < 9; k++) begin
            wait_idle(s);
            vld[s]  = 1'b1;
            i_count = 4'(k);
            i_data  = p[k];
            @(negedge clk);
            if (junk && k == 4) begin
                wait_idle(s);
                vld[s]  = 1'b1;
                i_count = 4'd11;
                i_data  = 14'd9999;
                @(negedge clk);
            end
        end
        vld[s]  = 1'b0;
        i_count = '0;
        i_data  = '0;
    endtask

    task automatic send_block(input int s, input win_t a, input win_t b, input win_t c,
                              input win_t d);
        send_win(s, a, 1'b0);
        send_win(s, b, 1'b0);
        send_win(s, c, 1'b0);
        send_win(s, d, 1'b0);
    endtask

    // Waits for the burst, checks n outputs on consecutive cycles, then the idle cycle after.
    task automatic expect_block(input int s, input string tag, input int n,
                                input int d0, input int d1, input int d2, input int d3,
                                input int a0, input int a1, input int a2, input int a3,
                                input int lat);
        int ed [4];
        int ea [4];
        int w = 0;
        ed = '{d0, d1, d2, d3};
        ea = '{a0, a1, a2, a3};
        while (ov[s] !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (lat >= 0) check($sformatf("%s latency", tag), w, lat);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s valid%0d", tag, i), ov[s], 1);
            check($sformatf("%s data%0d", tag, i), od[s], ed[i]);
            check($sformatf("%s angle%0d", tag, i), oa[s], ea[i]);
            check($sformatf("%s idx%0d", tag, i), oi[s], i);
            check($sformatf("%s finish%0d", tag, i), ff[s], (i == n - 1) ? 1 : 0);
            @(negedge clk);
        end
        check($sformatf("%s idle valid", tag), ov[s], 0);
        check($sformatf("%s idle data", tag), od[s], 0);
        check($sformatf("%s idle finish", tag), ff[s], 0);
    endtask

    vec_t tbl [12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        vld     = '0;
        i_data  = '0;
        i_count = '0;
        mode    = '0;

        tbl[0]  = '{edge_r(100),                     2'd0, 1'b0, 400,   0};
        tbl[1]  = '{w9(0,0,0, 0,0,0, 100,100,100),   2'd1, 1'b0, 400,   2};
        tbl[2]  = '{flat(50),                        2'd2, 1'b1, 0,     1};
        tbl[3]  = '{w9(100,0,0, 100,0,0, 100,0,0),   2'd0, 1'b0, 400,   0};
        tbl[4]  = '{w9(0,0,0, 0,0,100, 0,100,100),   2'd0, 1'b1, 600,   1};
        tbl[5]  = '{w9(0,0,0, 100,0,0, 100,100,0),   2'd3, 1'b0, 600,   3};
        tbl[6]  = '{w9(0,100,100, 0,0,100, 0,0,0),   2'd0, 1'b0, 600,   3};
        tbl[7]  = '{w9(0,0,0, 0,0,128, 0,53,0),      2'd0, 1'b0, 362,   1};
        tbl[8]  = '{w9(0,0,0, 0,0,128, 0,52,0),      2'd0, 1'b1, 360,   0};
        tbl[9]  = '{w9(0,0,0, 0,0,128, 0,309,0),     2'd0, 1'b0, 874,   1};
        tbl[10] = '{w9(0,0,0, 0,0,128, 0,310,0),     2'd2, 1'b0, 876,   2};
        tbl[11] = '{edge_r(16383),                   2'd1, 1'b0, 65532, 0};

        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset valid%0d", s), ov[s], 0);
            check($sformatf("reset data%0d", s), od[s], 0);
            check($sformatf("reset finish%0d", s), ff[s], 0);
            check($sformatf("reset busy%0d", s), bz[s], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Single-pixel blocks: magnitude, angle sectors and sector boundaries.
        for (int i = 0; i < 12; i++) begin
            mode = tbl[i].md;
            send_win(0, tbl[i].pix, tbl[i].junk);
            expect_block(0, $sformatf("vec%0d", i), 1, tbl[i].exp_g, 0, 0, 0,
                         tbl[i].exp_a, 0, 0, 0, 3);
        end

        // Taps offered while busy are dropped; the following window is unaffected.
        mode = 2'd0;
        send_win(0, edge_r(16383), 1'b0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("drop busy%0d", k), bz[0], 1);
            vld[0]  = 1'b1;
            i_count = 4'(k * 4);
            i_data  = 14'd1000;
            @(negedge clk);
        end
        vld[0] = 1'b0;
        check("drop out valid", ov[0], 1);
        check("drop out data", od[0], 65532);
        check("drop out finish", ff[0], 1);
        @(negedge clk);
        send_win(0, flat(50), 1'b0);
        expect_block(0, "after drop", 1, 0, 0, 0, 0, 1, 0, 0, 0, 3);

        // 2x2 blocks: suppression along each direction, modes and threshold.
        mode = 2'd0;
        send_block(1, edge_r(100), edge_r(75), flat(50), flat(50));
        expect_block(1, "blkA m0", 4, 400, 0, 0, 0, 0, 0, 1, 1, 3);
        mode = 2'd1;
        send_block(1, edge_r(100), edge_r(75), flat(50), flat(50));
        expect_block(1, "blkA m1", 4, 400, 300, 0, 0, 0, 0, 1, 1, 3);
        mode = 2'd2;
        send_block(2, edge_r(100), edge_r(75), flat(50), flat(50));
        expect_block(2, "blkA m2 thr", 4, 400, 0, 0, 0, 0, 0, 1, 1, 3);
        send_block(1, edge_r(75), flat(0), flat(0), flat(0));
        expect_block(1, "blkB m2", 4, 300, 0, 0, 0, 0, 1, 1, 1, 3);
        send_block(2, edge_r(75), flat(0), flat(0), flat(0));
        expect_block(2, "blkB m2 thr", 4, 0, 0, 0, 0, 0, 1, 1, 1, 3);
        mode = 2'd0;
        send_block(1, edge_r(100), edge_r(100), flat(0), flat(0));
        expect_block(1, "tie", 4, 400, 400, 0, 0, 0, 0, 1, 1, -1);
        send_block(1, w9(0,0,0, 0,0,0, 100,100,100), flat(0),
                   w9(0,0,0, 0,0,0, 50,50,50), flat(0));
        expect_block(1, "vert", 4, 400, 0, 0, 0, 2, 1, 2, 1, -1);
        send_block(1, w9(0,0,0, 0,0,100, 0,100,100), w9(0,0,0, 100,0,0, 100,100,0),
                   w9(0,0,0, 50,0,0, 50,50,0), w9(0,0,0, 0,0,50, 0,50,50));
        expect_block(1, "diag", 4, 600, 600, 0, 0, 1, 3, 3, 1, -1);

        // Mode is held from the first tap of the block.
        mode = 2'd1;
        send_win(1, edge_r(100), 1'b0);
        mode = 2'd0;
        send_win(1, edge_r(75), 1'b0);
        send_win(1, flat(50), 1'b0);
        send_win(1, flat(50), 1'b0);
        expect_block(1, "mode hold", 4, 400, 300, 0, 0, 0, 0, 1, 1, -1);

        // Reset after two slots are stored discards them.
        mode = 2'd1;
        send_win(1, edge_r(200), 1'b0);
        send_win(1, edge_r(150), 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst mid busy", bz[1], 0);
        check("rst mid valid", ov[1], 0);
        rst = 1'b0;
        mode = 2'd0;
        send_block(1, edge_r(100), edge_r(75), flat(50), flat(50));
        expect_block(1, "post rst", 4, 400, 0, 0, 0, 0, 0, 1, 1, 3);

        // Reset in the middle of a burst cuts it short with no finish pulse.
        send_block(1, edge_r(100), edge_r(75), flat(50), flat(50));
        begin
            int w = 0;
            while (ov[1] !== 1'b1 && w < 40) begin
                @(negedge clk);
                w++;
            end
        end
        @(negedge clk);
        check("emit rst pre valid", ov[1], 1);
        rst = 1'b1;
        #1;
        check("emit rst valid", ov[1], 0);
        check("emit rst data", od[1], 0);
        check("emit rst finish", ff[1], 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("emit rst quiet%0d", k), ov[1], 0);
        end
        mode = 2'd1;
        send_block(1, edge_r(100), edge_r(75), flat(50), flat(50));
        expect_block(1, "after emit rst", 4, 400, 300, 0, 0, 0, 0, 1, 1, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
